// File: rtl/calc1_unit.sv
`default_nettype none
// ============================================================================
// Module   : calc1_unit
// Brief    : Four independent two-cycle 32-bit unsigned calculator channels
//            (ADD, SUB, SHL, SHR) with one-cycle result/response pulses.
//            Optional macro CALC1_RESULT_HOLD_EN keeps out_dataN at the last
//            result after the response cycle.
// Revision : 1.0 - initial release
// ============================================================================
module calc1_unit #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic              c_clk,
  input  logic [1:7]        reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:1]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:1]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:1]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:1]        out_resp4
);

  localparam logic [3:0] c_cmd_add = 4'd1;
  localparam logic [3:0] c_cmd_sub = 4'd2;
  localparam logic [3:0] c_cmd_shl = 4'd5;
  localparam logic [3:0] c_cmd_shr = 4'd6;

  localparam logic [1:0] c_resp_none = 2'd0;
  localparam logic [1:0] c_resp_ok   = 2'd1;
  localparam logic [1:0] c_resp_err  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic              w_rst;
  logic [3:0]        w_cmd [NUM_PORTS];
  logic [DATA_W-1:0] w_din [NUM_PORTS];

  // Any reset bit clears the whole block.
  assign w_rst = |reset;

  assign w_cmd[0] = req1_cmd_in;
  assign w_cmd[1] = req2_cmd_in;
  assign w_cmd[2] = req3_cmd_in;
  assign w_cmd[3] = req4_cmd_in;
  assign w_din[0] = req1_data_in;
  assign w_din[1] = req2_data_in;
  assign w_din[2] = req3_data_in;
  assign w_din[3] = req4_data_in;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
    state_t            r_state;
    logic [3:0]        r_cmd;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_result;
    logic [1:0]        w_resp;

    assign w_sum = {1'b0, r_op1} + {1'b0, w_din[gi]};

    // Operand 2 is taken straight from the input in the OP2 cycle.
    always_comb begin
      w_result = '0;
      w_resp   = c_resp_err;
      case (r_cmd)
        c_cmd_add: begin
          if (!w_sum[DATA_W]) begin
            w_result = w_sum[DATA_W-1:0];
            w_resp   = c_resp_ok;
          end
        end
        c_cmd_sub: begin
          if (w_din[gi] <= r_op1) begin
            w_result = r_op1 - w_din[gi];
            w_resp   = c_resp_ok;
          end
        end
        c_cmd_shl: begin
          w_result = r_op1 << w_din[gi][4:0];
          w_resp   = c_resp_ok;
        end
        c_cmd_shr: begin
          w_result = r_op1 >> w_din[gi][4:0];
          w_resp   = c_resp_ok;
        end
        default: begin
          w_result = '0;
          w_resp   = c_resp_err;
        end
      endcase
    end

    always_ff @(posedge c_clk or posedge w_rst) begin
      if (w_rst) begin
        r_state <= ST_IDLE;
        r_cmd   <= '0;
        r_op1   <= '0;
        r_data  <= '0;
        r_resp  <= c_resp_none;
      end else begin
        case (r_state)
          ST_OP2: begin
            r_data  <= w_result;
            r_resp  <= w_resp;
            r_state <= ST_RESP;
          end
          default: begin
            // RESP behaves as IDLE so a command can follow back-to-back.
            r_resp <= c_resp_none;
`ifndef CALC1_RESULT_HOLD_EN
            r_data <= '0;
`endif
            if (w_cmd[gi] != 4'd0) begin
              r_cmd   <= w_cmd[gi];
              r_op1   <= w_din[gi];
              r_state <= ST_OP2;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign out_data1 = g_chan[0].r_data;
  assign out_resp1 = g_chan[0].r_resp;
  assign out_data2 = g_chan[1].r_data;
  assign out_resp2 = g_chan[1].r_resp;
  assign out_data3 = g_chan[2].r_data;
  assign out_resp3 = g_chan[2].r_resp;
  assign out_data4 = g_chan[3].r_data;
  assign out_resp4 = g_chan[3].r_resp;

endmodule
`default_nettype wire

// File: tb/tb_calc1_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc1_unit
// Brief    : Scoreboard bench for calc1_unit; stimulus pushes expected
//            responses per port, a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc1_unit;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:7]  reset;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [31:0] od   [4];
  logic [1:0]  orsp [4];

  exp_t        sbq  [4][$];
  logic [31:0] last [4];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc1_unit dut (
    .c_clk        (clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (din[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (din[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (din[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (din[3]),
    .out_data1    (od[0]),
    .out_resp1    (orsp[0]),
    .out_data2    (od[1]),
    .out_resp2    (orsp[1]),
    .out_data3    (od[2]),
    .out_resp3    (orsp[2]),
    .out_data4    (od[3]),
    .out_resp4    (orsp[3])
  );

  task automatic chk(input string name, input int p,
                     input logic [31:0] ad, input logic [1:0] ar,
                     input logic [31:0] ed, input logic [1:0] er);
    checks++;
    if (ad !== ed || ar !== er) begin
      failures++;
      $display("FAIL %s port%0d cyc=%0d: got data=%h resp=%0d, want data=%h resp=%0d",
               name, p + 1, cyc, ad, ar, ed, er);
    end
  endtask

  // Monitor: a response is due exactly at the recorded cycle, else outputs idle.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      exp_t e;
      if (|reset) last[p] = '0;
      if (sbq[p].size() > 0 && sbq[p][0].cyc < cyc) begin
        e = sbq[p].pop_front();
        checks++;
        failures++;
        $display("FAIL missed_resp port%0d: no response at cyc=%0d, want data=%h resp=%0d",
                 p + 1, e.cyc, e.data, e.resp);
      end
      if (sbq[p].size() > 0 && sbq[p][0].cyc == cyc) begin
        e = sbq[p].pop_front();
        chk("resp", p, od[p], orsp[p], e.data, e.resp);
        last[p] = e.data;
      end else begin
`ifdef CALC1_RESULT_HOLD_EN
        chk("idle", p, od[p], orsp[p], last[p], 2'd0);
`else
        chk("idle", p, od[p], orsp[p], 32'h0, 2'd0);
`endif
      end
    end
  end

  // Entered just after a rising edge; returns just after the response edge.
  task automatic issue(input int p, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic [1:0] er);
    exp_t e;
    e.cyc  = cyc + 2;
    e.data = ed;
    e.resp = er;
    sbq[p].push_back(e);
    cmd[p] = c;
    din[p] = a;
    @(posedge clk); #1;
    cmd[p] = 4'hF;   // must be ignored while operand 2 is captured
    din[p] = b;
    @(posedge clk); #1;
    cmd[p] = 4'h0;
    din[p] = 32'h0;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd[p]  = 4'h0;
      din[p]  = 32'h0;
      last[p] = 32'h0;
    end
    reset = 7'h7F;
    repeat (4) @(posedge clk);
    #1 reset = 7'h00;
    @(posedge clk); #1;

    // Basic ADD cases
    issue(0, 4'd1, 32'h00000001, 32'h1FFFFFFF, 32'h20000000, 2'd1);
    issue(0, 4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF, 32'h3FFFFFFE, 2'd1);
    issue(0, 4'd1, 32'h00000000, 32'h00000000, 32'h00000000, 2'd1);
    // Error cases
    issue(0, 4'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 2'd2);
    issue(0, 4'd2, 32'h00000001, 32'h0000000F, 32'h00000000, 2'd2);
    issue(0, 4'd3, 32'h00000005, 32'h00000007, 32'h00000000, 2'd2);
    issue(0, 4'd4, 32'h00000005, 32'h00000007, 32'h00000000, 2'd2);
    issue(0, 4'd15, 32'h00000005, 32'h00000007, 32'h00000000, 2'd2);
    // SUB/shift boundaries
    issue(0, 4'd2, 32'h00000010, 32'h00000003, 32'h0000000D, 2'd1);
    issue(0, 4'd2, 32'h00000005, 32'h00000005, 32'h00000000, 2'd1);
    issue(0, 4'd5, 32'h00000001, 32'h00000021, 32'h00000002, 2'd1);
    issue(0, 4'd6, 32'hF0000000, 32'h0000001F, 32'h00000001, 2'd1);
    issue(0, 4'd5, 32'h80000001, 32'h00000001, 32'h00000002, 2'd1);
    issue(1, 4'd2, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'd1);

    // Walking-one sweep
    for (int k = 0; k <= 30; k++) begin
      logic [31:0] x;
      logic [31:0] h;
      x = 32'h1 << k;
      h = 32'h80000000 >> k;
      issue(0, 4'd1, x, 32'h0, x, 2'd1);
      issue(0, 4'd5, x, 32'h1, x << 1, 2'd1);
      issue(0, 4'd6, h, 32'h1, h >> 1, 2'd1);
    end
    for (int a = 1; a <= 31; a++) begin
      logic [31:0] s;
      s = 32'h1 << a;
      issue(0, 4'd5, 32'h1, a, s, 2'd1);
    end

    // cmd=0 with random data must produce nothing
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) din[p] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) din[p] = 32'h0;

    // Concurrent ADDs on all ports
    fork
      issue(0, 4'd1, 32'h00000010, 32'h00000020, 32'h00000030, 2'd1);
      issue(1, 4'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 2'd1);
      issue(2, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2'd2);
      issue(3, 4'd1, 32'h12345678, 32'h11111111, 32'h23456789, 2'd1);
    join

    // Reset during OP2 aborts the command
    cmd[2] = 4'd1;
    din[2] = 32'h00000005;
    @(posedge clk); #1;
    reset[1] = 1'b1;
    cmd[2] = 4'h0;
    din[2] = 32'h00000006;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    din[2] = 32'h0;
    @(posedge clk); #1;
    issue(2, 4'd1, 32'h00000005, 32'h00000006, 32'h0000000B, 2'd1);

    repeat (4) @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (sbq[p].size() != 0) begin
        failures++;
        $display("FAIL leftover port%0d: got %0d pending responses, want 0", p + 1, sbq[p].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
